// File: rtl/decodificador_7seg_varredura_pkg.sv
// Shared 7-segment definitions: glyph patterns (bit6=a .. bit0=g), blank pattern
// and the state encoding of the scan decoder.
package decodificador_7seg_varredura_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [6:0] SEG_VAZIO = 7'b0000000;

    typedef enum logic {
        ESPERA    = 1'b0,
        CAPTURADO = 1'b1
    } estado_t;

    // Forward direction, kept here so encoder and decoder share one table.
    function automatic logic [6:0] hex_para_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decodificador_7seg_varredura_seg7_para_hex.sv
// Combinational inverse of the hex-to-7-segment table: recovers the nibble and
// flags whether the pattern is a known glyph or a blank digit.
module seg7_para_hex
    import decodificador_7seg_varredura_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       casa,
    output logic       vazio
);

    always_comb begin
        nibble = 4'h0;
        casa   = 1'b1;
        case (seg)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: casa = 1'b0;
        endcase
    end

    assign vazio = (seg == SEG_VAZIO);

endmodule

// File: rtl/decodificador_7seg_varredura.sv
// Readback of a multiplexed 7-segment bus: waits for a stable dwell on one digit,
// captures it once, decodes it to a nibble and tracks complete scan frames.
module decodificador_7seg_varredura
    import decodificador_7seg_varredura_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int ESTAVEL   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_in,
    input  logic [N_DIGITOS-1:0]   dig_en,
    output logic [4*N_DIGITOS-1:0] hex_out,
    output logic [N_DIGITOS-1:0]   digito_valido,
    output logic                   quadro_completo,
    output logic                   erro_padrao
);

    localparam int CW = $clog2(ESTAVEL + 1);
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(ESTAVEL);

    logic [6:0]             seg_r;
    logic [N_DIGITOS-1:0]   en_r;
    logic [CW-1:0]          cnt;
    estado_t                estado, estado_prox;

    logic [N_DIGITOS-1:0]   mascara, mascara_com;
    logic [4*N_DIGITOS-1:0] hex_r;
    logic [N_DIGITOS-1:0]   valido_r;
    logic                   quadro_r, erro_r;

    logic                   mudou, um_quente, captura;
    logic [3:0]             n_ativos;
    logic [IW-1:0]          idx;
    logic [3:0]             nib;
    logic                   casa, vazio;

    // A change is flagged on the edge where the newly registered value differs
    // from the one already held, so the dwell count starts on that same edge.
    assign mudou = (seg_in != seg_r) || (dig_en != en_r);

    always_comb begin
        n_ativos = 4'd0;
        idx      = '0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (en_r[i]) begin
                n_ativos = n_ativos + 4'd1;
                idx      = IW'(i);
            end
        end
    end

    assign um_quente = (n_ativos == 4'd1);

    seg7_para_hex u_dec (
        .seg    (seg_r),
        .nibble (nib),
        .casa   (casa),
        .vazio  (vazio)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= '0;
            en_r  <= '0;
            cnt   <= '0;
        end else begin
            seg_r <= seg_in;
            en_r  <= dig_en;
            if (mudou || !um_quente) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ESPERA;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        if (mudou || !um_quente) begin
            estado_prox = ESPERA;
        end else if ((estado == ESPERA) && (cnt == CNT_MAX)) begin
            estado_prox = CAPTURADO;
        end
    end

    always_comb begin
        captura     = (estado == ESPERA) && um_quente && (cnt == CNT_MAX);
        mascara_com = mascara | en_r;
    end

    // Blank and unknown patterns still count the digit as seen for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_r    <= '0;
            valido_r <= '0;
            mascara  <= '0;
            quadro_r <= 1'b0;
            erro_r   <= 1'b0;
        end else begin
            quadro_r <= 1'b0;
            erro_r   <= 1'b0;
            if (captura) begin
                if (casa) begin
                    hex_r[4*idx +: 4] <= nib;
                    valido_r[idx]     <= 1'b1;
                end else begin
                    valido_r[idx] <= 1'b0;
                    erro_r        <= !vazio;
                end
                if (mascara_com == '1) begin
                    quadro_r <= 1'b1;
                    mascara  <= '0;
                end else begin
                    mascara <= mascara_com;
                end
            end
        end
    end

    assign hex_out         = hex_r;
    assign digito_valido   = valido_r;
    assign quadro_completo = quadro_r;
    assign erro_padrao     = erro_r;

endmodule

// File: tb/tb_decodificador_7seg_varredura.sv
// Bench for the 7-segment scan decoder: run-length reference model plus
// directed scenarios and a randomized scan.
module tb_decodificador_7seg_varredura;

    localparam int N = 4;
    localparam int E = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg_in;
    logic [N-1:0]   dig_en;
    logic [4*N-1:0] hex_out;
    logic [N-1:0]   digito_valido;
    logic           quadro_completo;
    logic           erro_padrao;

    int ncmp = 0;
    int nbad = 0;

    decodificador_7seg_varredura #(.N_DIGITOS(N), .ESTAVEL(E)) dut (
        .clk             (clk),
        .rst             (rst),
        .seg_in          (seg_in),
        .dig_en          (dig_en),
        .hex_out         (hex_out),
        .digito_valido   (digito_valido),
        .quadro_completo (quadro_completo),
        .erro_padrao     (erro_padrao)
    );

    always #5 clk = ~clk;

    logic [6:0] tabela [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: every run of identical one-hot samples lasting E+1
    // edges yields exactly one capture on the following edge.
    logic [4*N-1:0] exp_hex;
    logic [N-1:0]   exp_val;
    logic           exp_quadro, exp_erro;
    logic [N-1:0]   m_mask;
    logic [6+N:0]   last_s;
    int             run_len;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_hex = '0; exp_val = '0; exp_quadro = 0; exp_erro = 0;
            m_mask = '0; last_s = '0; run_len = 0;
        end else begin
            exp_quadro = 0;
            exp_erro   = 0;
            if (run_len == E + 1 && $countones(last_s[N-1:0]) == 1) begin
                int  dig;
                bit  hit;
                dig = 0;
                hit = 0;
                for (int b = 0; b < N; b++) if (last_s[b]) dig = b;
                for (int v = 0; v < 16; v++) begin
                    if (tabela[v] == last_s[6+N:N]) begin
                        hit = 1;
                        exp_hex[4*dig +: 4] = v[3:0];
                    end
                end
                if (hit) exp_val[dig] = 1'b1;
                else begin
                    exp_val[dig] = 1'b0;
                    if (last_s[6+N:N] != 7'b0) exp_erro = 1;
                end
                m_mask[dig] = 1'b1;
                if (&m_mask) begin
                    exp_quadro = 1;
                    m_mask = '0;
                end
            end
            if ({seg_in, dig_en} == last_s) run_len++;
            else begin
                run_len = 1;
                last_s  = {seg_in, dig_en};
            end
        end
    end

    task automatic test_reset_inicial();
        rst = 1'b1; seg_in = '0; dig_en = '0;
        repeat (3) @(negedge clk);
        ncmp++;
        if (hex_out !== '0 || digito_valido !== '0 || quadro_completo !== 1'b0 || erro_padrao !== 1'b0) begin
            nbad++;
            $display("FAIL reset_inicial got hex=%h val=%b q=%b e=%b want all zero",
                     hex_out, digito_valido, quadro_completo, erro_padrao);
        end
        rst = 1'b0;
    endtask

    task automatic test_captura_unica();
        seg_in = 7'b1111001; dig_en = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            ncmp++;
            if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                nbad++;
                $display("FAIL captura_ciclo%0d got hex=%h val=%b q=%b e=%b want hex=%h val=%b q=%b e=%b", c,
                         hex_out, digito_valido, quadro_completo, erro_padrao, exp_hex, exp_val, exp_quadro, exp_erro);
            end
            if (c == 5) begin
                ncmp++;
                if (digito_valido !== 4'b0000) begin
                    nbad++;
                    $display("FAIL captura_cedo got val=%b want 0000", digito_valido);
                end
            end
            if (c == 6) begin
                ncmp++;
                if (hex_out[3:0] !== 4'h3 || digito_valido !== 4'b0001) begin
                    nbad++;
                    $display("FAIL captura_latencia got hex0=%h val=%b want hex0=3 val=0001", hex_out[3:0], digito_valido);
                end
            end
        end
    endtask

    task automatic test_varredura_completa();
        logic [3:0] nib [4];
        int pulsos, ciclo_pulso, ciclo;
        nib[0] = 4'h1; nib[1] = 4'hA; nib[2] = 4'h0; nib[3] = 4'hF;
        pulsos = 0; ciclo_pulso = -1; ciclo = 0;
        for (int d = 0; d < 4; d++) begin
            seg_in = tabela[nib[d]];
            dig_en = 4'(1 << d);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                ciclo++;
                if (quadro_completo === 1'b1) begin pulsos++; ciclo_pulso = ciclo; end
                ncmp++;
                if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                    nbad++;
                    $display("FAIL varredura_ciclo%0d got hex=%h val=%b q=%b e=%b want hex=%h val=%b q=%b e=%b", ciclo,
                             hex_out, digito_valido, quadro_completo, erro_padrao, exp_hex, exp_val, exp_quadro, exp_erro);
                end
            end
        end
        seg_in = '0; dig_en = '0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (hex_out !== 16'hF0A1 || digito_valido !== 4'b1111) begin
            nbad++;
            $display("FAIL varredura_final got hex=%h val=%b want hex=f0a1 val=1111", hex_out, digito_valido);
        end
        ncmp++;
        if (pulsos != 1 || ciclo_pulso != 24) begin
            nbad++;
            $display("FAIL varredura_quadro got pulses=%0d at=%0d want pulses=1 at=24", pulsos, ciclo_pulso);
        end
    endtask

    task automatic test_glitch();
        dig_en = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            seg_in = ((c / 2) % 2 == 1) ? 7'b1101101 : 7'b0110000;
            @(negedge clk);
            ncmp++;
            if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                nbad++;
                $display("FAIL glitch_ciclo%0d got hex=%h val=%b want hex=%h val=%b", c, hex_out, digito_valido, exp_hex, exp_val);
            end
        end
        seg_in = '0; dig_en = '0;
        @(negedge clk);
        ncmp++;
        if (hex_out[7:4] !== 4'hA || digito_valido[1] !== 1'b1) begin
            nbad++;
            $display("FAIL glitch_retido got hex1=%h val1=%b want hex1=a val1=1", hex_out[7:4], digito_valido[1]);
        end
    endtask

    task automatic test_padrao_invalido();
        int erros;
        erros = 0;
        seg_in = 7'b1010101; dig_en = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) begin seg_in = '0; dig_en = '0; end
            @(negedge clk);
            if (erro_padrao === 1'b1) erros++;
            ncmp++;
            if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                nbad++;
                $display("FAIL invalido_ciclo%0d got val=%b e=%b want val=%b e=%b", c, digito_valido, erro_padrao, exp_val, exp_erro);
            end
        end
        ncmp++;
        if (erros != 1 || digito_valido[2] !== 1'b0 || hex_out[11:8] !== 4'h0) begin
            nbad++;
            $display("FAIL invalido_resumo got errs=%0d val2=%b hex2=%h want errs=1 val2=0 hex2=0", erros, digito_valido[2], hex_out[11:8]);
        end
    endtask

    task automatic test_enables_e_vazio();
        int erros, pulsos;
        erros = 0; pulsos = 0;
        seg_in = 7'b0110000; dig_en = 4'b0011;
        repeat (10) @(negedge clk);
        ncmp++;
        if (hex_out !== 16'hF0A1 || erro_padrao !== 1'b0 || quadro_completo !== 1'b0) begin
            nbad++;
            $display("FAIL multi_hot got hex=%h e=%b q=%b want hex=f0a1 e=0 q=0", hex_out, erro_padrao, quadro_completo);
        end
        seg_in = 7'b0000000; dig_en = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            if (c == 6) dig_en = '0;
            @(negedge clk);
            if (erro_padrao === 1'b1) erros++;
        end
        ncmp++;
        if (erros != 0 || digito_valido[3] !== 1'b0 || hex_out[15:12] !== 4'hF) begin
            nbad++;
            $display("FAIL vazio got errs=%0d val3=%b hex3=%h want errs=0 val3=0 hex3=f", erros, digito_valido[3], hex_out[15:12]);
        end
        for (int d = 0; d < 2; d++) begin
            seg_in = (d == 0) ? tabela[5] : tabela[6];
            dig_en = 4'(1 << d);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (quadro_completo === 1'b1) pulsos++;
                ncmp++;
                if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                    nbad++;
                    $display("FAIL fecha_quadro_ciclo%0d got hex=%h q=%b want hex=%h q=%b", c, hex_out, quadro_completo, exp_hex, exp_quadro);
                end
            end
        end
        seg_in = '0; dig_en = '0;
        @(negedge clk);
        ncmp++;
        if (pulsos != 1 || hex_out !== 16'hF065 || digito_valido !== 4'b0011) begin
            nbad++;
            $display("FAIL fecha_quadro got pulses=%0d hex=%h val=%b want pulses=1 hex=f065 val=0011", pulsos, hex_out, digito_valido);
        end
    endtask

    task automatic test_aleatorio();
        for (int t = 0; t < 200; t++) begin
            int hold;
            if ($urandom_range(0, 3) != 0) seg_in = tabela[$urandom_range(0, 15)];
            else seg_in = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0) dig_en = 4'(1 << $urandom_range(0, N - 1));
            else dig_en = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                ncmp++;
                if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                    nbad++;
                    $display("FAIL aleatorio_t%0d got hex=%h val=%b q=%b e=%b want hex=%h val=%b q=%b e=%b", t,
                             hex_out, digito_valido, quadro_completo, erro_padrao, exp_hex, exp_val, exp_quadro, exp_erro);
                end
            end
        end
    endtask

    task automatic test_reset_meio();
        seg_in = 7'b1110000; dig_en = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        ncmp++;
        if (hex_out !== '0 || digito_valido !== '0 || quadro_completo !== 1'b0 || erro_padrao !== 1'b0) begin
            nbad++;
            $display("FAIL reset_assincrono got hex=%h val=%b q=%b e=%b want all zero",
                     hex_out, digito_valido, quadro_completo, erro_padrao);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ncmp++;
            if (hex_out !== exp_hex || digito_valido !== exp_val || quadro_completo !== exp_quadro || erro_padrao !== exp_erro) begin
                nbad++;
                $display("FAIL pos_reset_ciclo%0d got hex=%h val=%b want hex=%h val=%b", c, hex_out, digito_valido, exp_hex, exp_val);
            end
            if (c == 5) begin
                ncmp++;
                if (digito_valido !== 4'b0000) begin
                    nbad++;
                    $display("FAIL pos_reset_cedo got val=%b want 0000", digito_valido);
                end
            end
            if (c == 6) begin
                ncmp++;
                if (hex_out !== 16'h0007 || digito_valido !== 4'b0001) begin
                    nbad++;
                    $display("FAIL pos_reset_captura got hex=%h val=%b want hex=0007 val=0001", hex_out, digito_valido);
                end
            end
        end
    endtask

    initial begin
        test_reset_inicial();
        test_captura_unica();
        test_varredura_completa();
        test_glitch();
        test_padrao_invalido();
        test_enables_e_vazio();
        test_aleatorio();
        test_reset_meio();
        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decodificador_7seg_varredura.md
Name: decodificador_7seg_varredura

Overview:
- Reverse direction of the hex-to-7-segment encoder: monitors a multiplexed 7-segment display bus and recovers the hex nibble shown on each digit.
- Samples segment lines plus one-hot digit enables, requires a stable dwell before capture, and decodes each pattern back to 4 bits.
- Sits on the display side of the design as a self-check and readback path.

Parameters:
- N_DIGITOS, 4, number of multiplexed digits (1..8).
- ESTAVEL, 4, consecutive stable cycles required before capture (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- seg_in  input  7  segment lines, active-high; bit6=a … bit0=g (same encoding as the encoder).
- dig_en  input  N_DIGITOS  digit enables, one-hot when a digit is driven.
- hex_out  output  4*N_DIGITOS  recovered nibbles; digit i at [4i+3:4i].
- digito_valido  output  N_DIGITOS  bit i = last capture on digit i decoded successfully.
- quadro_completo  output  1  one-cycle pulse when every digit has been captured since the previous pulse.
- erro_padrao  output  1  one-cycle pulse when a non-blank pattern matches no hex glyph.

Behaviour:
- Reset: every output register, the input registers, the counter and the capture mask go to 0; state = ESPERA. Applies immediately, including mid-count.
- Input stage:
  - seg_in and dig_en are registered every cycle (seg_r, en_r).
  - "Changed" means {seg_r, en_r} differs from the previous registered value.
- Stability counter:
  - Width is clog2(ESTAVEL+1).
  - Cleared on a change, or when en_r is not one-hot (zero or multi-hot).
  - Otherwise increments, saturating at ESTAVEL.
- State machine:
  - ESPERA: when counter == ESTAVEL and en_r is one-hot, perform a capture, then go to CAPTURADO.
  - CAPTURADO: no further capture. Any change, or en_r not one-hot, clears the counter and returns to ESPERA.
  - Each dwell therefore produces exactly one capture.
- Latency: inputs held constant from edge k produce capture outputs visible after edge k+ESTAVEL+1.
- Capture on digit i (index of the one-hot bit in en_r):
  - Pattern matches a glyph 0–F of the encoder table: hex_out[i] = nibble, digito_valido[i] = 1.
  - seg_r == 0000000 (blank): digito_valido[i] = 0, hex_out[i] held, no error.
  - Any other pattern: digito_valido[i] = 0, hex_out[i] held, erro_padrao pulses for 1 cycle.
  - In all three cases the mask bit i is set.
- Frame detection:
  - When the mask becomes all-ones, quadro_completo pulses on that same edge and the mask clears to 0.
  - Simultaneously, the current capture's bit is counted toward the completed frame.
  - A digit captured twice within one frame does not pulse.
- Untouched digits keep their nibble and valid bit indefinitely.
- The decode table is exactly the inverse of the encoder: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

Decomposition:
- Shared package:
  - The 16 segment-pattern constants (used by encoder and decoder).
  - Blank constant 7'b0000000.
  - State encoding ESPERA/CAPTURADO.
- Sub-module seg7_para_hex: combinational; seg[6:0] -> nibble[3:0], casa (match) and vazio (blank) flags.
- Top module holds the input registers, counter, FSM, mask and output registers.

Test Plan:
- Reset: assert rst for 3 cycles mid-activity -> hex_out=0, digito_valido=0, pulses=0 immediately; counter restarts after release.
- Single capture: dig_en=0001, seg_in=1111001 held 10 cycles -> hex_out[3:0]=3, digito_valido=0001, visible exactly 5 edges after hold start; no second update.
- Full scan: digits 0..3 shown for 6 cycles each with 1, A, 0, F -> hex_out=16'hF0A1, digito_valido=1111, quadro_completo one pulse on the digit-3 capture edge.
- Glitch rejection: dig_en=0010, seg_in toggles 0110000/1101101 every 2 cycles for 20 cycles -> no capture; hex_out[7:4] unchanged.
- Invalid glyph: dig_en=0100, seg_in=1010101 for 6 cycles -> erro_padrao single pulse, digito_valido[2]=0, hex_out[11:8] unchanged.
- Bad enables and blank: dig_en=0011 for 10 cycles -> nothing captured; dig_en=1000, seg_in=0000000 -> digito_valido[3]=0, no error, mask bit 3 set.
